daq_run_ctrl: RTL and testbench

Run controller for the ADC acquisition path. It polls a host command byte in the shared 32-byte handshake RAM through port B and sequences datapath reset, settling, run and halt. It drives the write-enable into the clock-crossing FIFO and writes status and accepted-word count back to the same RAM for the host to read. It sits in the 100 MHz clk domain and replaces the fixed-count veto logic and the command path of the user reset generator.

---
 rtl/daq_run_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_daq_run_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_run_ctrl.sv
// daq_run_ctrl: ADC acquisition run controller.
// Polls a host command byte in the shared handshake RAM (port B), sequences
// datapath reset / settle / run / halt, gates FIFO writes and reports the
// status byte and accepted-word count back to the RAM.
module daq_run_ctrl #(
   parameter int RD_LAT        = 1,
   parameter int RST_CYCLES    = 5,
   parameter int SETTLE_CYCLES = 450,
   parameter int POLL_INTERVAL = 16,
   parameter int CMD_ADDR      = 0,
   parameter int STAT_ADDR     = 1,
   parameter int LIMIT_ADDR    = 2,
   parameter int COUNT_ADDR    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] mem_rdata,
   output logic [7:0] mem_wdata,
   output logic [4:0] mem_addr,
   output logic       mem_en,
   output logic       mem_we,
   input  logic       fifo_full,
   input  logic       word_tick,
   output logic       dp_rst,
   output logic       wr_enable,
   output logic       overflow,
   output logic       done
);

   typedef enum logic [3:0] {
      B_WAIT, B_RD_CMD, B_LAT_CMD, B_RD_LIM, B_LAT_LIM,
      B_DEC, B_CLR, B_WR_STAT, B_WR_CNT
   } bus_t;

   // Encodings double as the status-byte state code.
   typedef enum logic [2:0] {
      M_IDLE = 3'd0, M_RESET = 3'd1, M_SETTLE = 3'd2, M_RUN = 3'd3, M_HALT = 3'd4
   } main_t;

   bus_t        bstate;
   main_t       mstate;
   logic [15:0] bcnt;
   logic [15:0] mcnt;
   logic [7:0]  cmd;
   logic [7:0]  lim;
   logic [7:0]  count;
   logic [7:0]  limit_reg;
   logic        run_pending;

   logic        cmd_vld;
   logic        do_reset;
   logic        do_stop;
   logic        do_start;
   logic [7:0]  cnt_nxt;
   logic        lim_hit;
   logic [7:0]  status;

   // Command is only acted on in the decode slot; RESET > STOP > START.
   assign cmd_vld  = (bstate == B_DEC);
   assign do_reset = cmd_vld & cmd[2];
   assign do_stop  = cmd_vld & ~cmd[2] & cmd[1];
   assign do_start = cmd_vld & ~cmd[2] & ~cmd[1] & cmd[0];

   // Count saturates at 255; the limit is tested against the post-tick count.
   assign cnt_nxt = (word_tick && count != 8'hFF) ? count + 8'd1 : count;
   assign lim_hit = (limit_reg != 8'd0) && (cnt_nxt == limit_reg);
   assign status  = {3'b000, done, overflow, mstate};

   // Port-B sequencer: wait, read cmd, read limit, decode, optional clear,
   // write status, write count. Bus outputs are registered with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         bstate    <= B_WAIT;
         bcnt      <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cmd       <= '0;
         lim       <= '0;
      end else begin
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         case (bstate)
            B_WAIT: begin
               if (bcnt == 16'(POLL_INTERVAL - 1)) begin
                  bcnt     <= '0;
                  bstate   <= B_RD_CMD;
                  mem_en   <= 1'b1;
                  mem_addr <= 5'(CMD_ADDR);
               end else begin
                  bcnt <= bcnt + 16'd1;
               end
            end
            B_RD_CMD: bstate <= B_LAT_CMD;
            B_LAT_CMD: begin
               if (bcnt == 16'(RD_LAT - 1)) begin
                  cmd      <= mem_rdata;
                  bcnt     <= '0;
                  bstate   <= B_RD_LIM;
                  mem_en   <= 1'b1;
                  mem_addr <= 5'(LIMIT_ADDR);
               end else begin
                  bcnt <= bcnt + 16'd1;
               end
            end
            B_RD_LIM: bstate <= B_LAT_LIM;
            B_LAT_LIM: begin
               if (bcnt == 16'(RD_LAT - 1)) begin
                  lim    <= mem_rdata;
                  bcnt   <= '0;
                  bstate <= B_DEC;
               end else begin
                  bcnt <= bcnt + 16'd1;
               end
            end
            B_DEC: begin
               mem_en <= 1'b1;
               mem_we <= 1'b1;
               if (cmd != 8'd0) begin
                  bstate    <= B_CLR;
                  mem_addr  <= 5'(CMD_ADDR);
                  mem_wdata <= 8'd0;
               end else begin
                  bstate    <= B_WR_STAT;
                  mem_addr  <= 5'(STAT_ADDR);
                  mem_wdata <= status;
               end
            end
            B_CLR: begin
               bstate    <= B_WR_STAT;
               mem_en    <= 1'b1;
               mem_we    <= 1'b1;
               mem_addr  <= 5'(STAT_ADDR);
               mem_wdata <= status;
            end
            B_WR_STAT: begin
               bstate    <= B_WR_CNT;
               mem_en    <= 1'b1;
               mem_we    <= 1'b1;
               mem_addr  <= 5'(COUNT_ADDR);
               mem_wdata <= count;
            end
            B_WR_CNT: begin
               bstate <= B_WAIT;
               bcnt   <= '0;
            end
            default: begin
               bstate <= B_WAIT;
               bcnt   <= '0;
            end
         endcase
      end
   end

   // Run sequencing: a RESET command anywhere, or START from IDLE/HALT,
   // restarts the datapath reset pulse and clears the run bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         mstate      <= M_IDLE;
         mcnt        <= '0;
         run_pending <= 1'b0;
         count       <= '0;
         limit_reg   <= '0;
         dp_rst      <= 1'b0;
         wr_enable   <= 1'b0;
         overflow    <= 1'b0;
         done        <= 1'b0;
      end else if (do_reset || (do_start && (mstate == M_IDLE || mstate == M_HALT))) begin
         mstate      <= M_RESET;
         mcnt        <= '0;
         run_pending <= ~do_reset;
         limit_reg   <= lim;
         count       <= '0;
         dp_rst      <= 1'b1;
         wr_enable   <= 1'b0;
         overflow    <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (mstate)
            M_RESET: begin
               if (mcnt == 16'(RST_CYCLES - 1)) begin
                  mcnt   <= '0;
                  dp_rst <= 1'b0;
                  mstate <= M_SETTLE;
               end else begin
                  mcnt <= mcnt + 16'd1;
               end
            end
            M_SETTLE: begin
               if (do_stop) run_pending <= 1'b0;
               if (mcnt == 16'(SETTLE_CYCLES - 1)) begin
                  mcnt <= '0;
                  if (run_pending && !do_stop) begin
                     mstate    <= M_RUN;
                     wr_enable <= 1'b1;
                  end else begin
                     mstate <= M_IDLE;
                  end
               end else begin
                  mcnt <= mcnt + 16'd1;
               end
            end
            M_RUN: begin
               count <= cnt_nxt;
               if (do_stop || fifo_full || lim_hit) begin
                  mstate    <= M_HALT;
                  wr_enable <= 1'b0;
                  if (fifo_full) overflow <= 1'b1;
                  if (lim_hit)   done     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_daq_run_ctrl.sv
// tb_daq_run_ctrl: bench for daq_run_ctrl with a handshake-RAM model,
// a poll-frame position / run-phase reference model, directed scenarios
// and a randomized host/datapath phase.
module tb_daq_run_ctrl;

   localparam int P      = 16;
   localparam int L      = 1;
   localparam int RSTC   = 5;
   localparam int SETTLE = 450;
   localparam int RDC    = P;             // frame slot of the cmd read strobe
   localparam int RDL    = P + L + 1;     // frame slot of the limit read strobe
   localparam int DEC    = P + 2 * L + 2; // frame slot in which the cmd acts

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] mem_rdata;
   logic [7:0] mem_wdata;
   logic [4:0] mem_addr;
   logic       mem_en;
   logic       mem_we;
   logic       fifo_full = 1'b0;
   logic       word_tick = 1'b0;
   logic       dp_rst;
   logic       wr_enable;
   logic       overflow;
   logic       done;

   logic       host_we   = 1'b0;
   logic [4:0] host_addr = '0;
   logic [7:0] host_data = '0;
   logic       ram_init  = 1'b1;
   logic [7:0] ram [32];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model state
   int         p = 0;
   int         ms = 0;
   int         mt = 0;
   int         runp = 0;
   int         cnt = 0;
   int         limr = 0;
   bit         m_ovf = 0;
   bit         m_done = 0;
   bit         m_clr = 0;
   logic [7:0] m_cmd = '0;
   logic [7:0] m_lim = '0;
   logic [7:0] snap_stat = '0;
   logic [7:0] snap_cnt = '0;

   bit          log_on = 0;
   logic [13:0] blog [$];
   logic [7:0]  cmd_tab [7] = '{8'h01, 8'h02, 8'h04, 8'h07, 8'hF1, 8'h0A, 8'h00};

   daq_run_ctrl dut (
      .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
      .fifo_full(fifo_full), .word_tick(word_tick), .dp_rst(dp_rst),
      .wr_enable(wr_enable), .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   // handshake RAM: host port plus the DUT's port B, one-cycle read latency
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 32; i++) ram[i] <= 8'h00;
         mem_rdata <= 8'h00;
      end else begin
         if (host_we) ram[host_addr] <= host_data;
         if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
         if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] stat_byte();
      return {3'b000, m_done, m_ovf, 3'(ms)};
   endfunction

   // Advance the model across one clock edge with the inputs about to be sampled.
   task automatic model_step(input bit wt, input bit ff, input bit r);
      int np, wpos;
      logic [2:0] c;
      bit dec, rs, st, go, hit;
      if (r) begin
         p = 0; ms = 0; mt = 0; runp = 0; cnt = 0; limr = 0;
         m_ovf = 0; m_done = 0; m_clr = 0; m_cmd = '0; m_lim = '0;
         return;
      end
      dec = (p == DEC);
      c   = m_cmd[2:0];
      rs  = dec && c[2];
      st  = dec && !c[2] && c[1];
      go  = dec && (c == 3'b001);
      if (p == RDC) m_cmd = ram[0];
      if (p == RDL) m_lim = ram[2];
      if (dec) m_clr = (m_cmd != 8'h00);
      np = (p == DEC + (m_clr ? 3 : 2)) ? 0 : p + 1;
      if (np > DEC) begin
         wpos = np - DEC - (m_clr ? 1 : 0);
         if (wpos == 1) snap_stat = stat_byte();
         if (wpos == 2) snap_cnt = 8'(cnt);
      end
      p = np;
      if (rs || (go && (ms == 0 || ms == 4))) begin
         ms = 1; mt = 0; runp = go ? 1 : 0; limr = int'(m_lim); cnt = 0; m_ovf = 0; m_done = 0;
      end else begin
         case (ms)
            1: begin
               mt++;
               if (mt == RSTC) begin ms = 2; mt = 0; end
            end
            2: begin
               if (st) runp = 0;
               mt++;
               if (mt == SETTLE) begin ms = (runp != 0) ? 3 : 0; mt = 0; end
            end
            3: begin
               if (wt && cnt < 255) cnt++;
               hit = (limr != 0) && (cnt == limr);
               if (st || ff || hit) begin
                  ms = 4;
                  if (ff)  m_ovf  = 1;
                  if (hit) m_done = 1;
               end
            end
            default: ;
         endcase
      end
   endtask

   // One clock: update model, let the edge pass, compare on the falling edge.
   task automatic tick();
      bit en, we;
      int wpos;
      logic [4:0] ad;
      logic [7:0] wd;
      model_step(word_tick, fifo_full, rst);
      @(negedge clk);
      cyc++;
      en = (p == RDC) || (p == RDL) || (p > DEC);
      we = (p > DEC);
      ad = '0;
      wd = '0;
      if (p == RDL) ad = 5'd2;
      if (p > DEC) begin
         wpos = p - DEC - (m_clr ? 1 : 0);
         case (wpos)
            1: begin ad = 5'd1; wd = snap_stat; end
            2: begin ad = 5'd3; wd = snap_cnt; end
            default: begin ad = 5'd0; wd = 8'h00; end
         endcase
      end
      chk("ctl", 32'({dp_rst, wr_enable, overflow, done}),
          32'({ms == 1, ms == 3, m_ovf, m_done}));
      chk("bus", 32'({mem_en, mem_we}), 32'({en, we}));
      if (en) chk("addr", 32'(mem_addr), 32'(ad));
      if (we) chk("wdata", 32'(mem_wdata), 32'(wd));
      if (log_on && mem_en) blog.push_back({mem_we, mem_addr, mem_wdata});
      word_tick = 1'b0;
      fifo_full = 1'b0;
      host_we   = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
      host_we = 1'b1; host_addr = a; host_data = d;
      tick();
   endtask

   task automatic finish_poll();
      int n = 0;
      do begin tick(); n++; end while (p != 0 && n < 64);
   endtask

   function automatic logic sig(input int which);
      case (which)
         0: return dp_rst;
         1: return wr_enable;
         default: return mem_en;
      endcase
   endfunction

   task automatic wait_sig(input string nm, input int which, input logic val, input int lim);
      int n = 0;
      while (sig(which) !== val && n < lim) begin tick(); n++; end
      if (sig(which) !== val) begin
         checks++;
         failures++;
         $display("FAIL %s: timeout after %0d cycles, wanted %0b", nm, n, val);
      end
   endtask

   initial begin
      int n, hi, r;

      // reset for three cycles
      for (int i = 0; i < 3; i++) begin
         rst = 1'b1;
         tick();
         chk("rst_out", 32'({dp_rst, wr_enable, overflow, done, mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
      end
      ram_init = 1'b0;

      // first poll: read cmd, read limit, write status, write count
      log_on = 1;
      n = 0;
      while (!mem_en && n < 100) begin tick(); n++; end
      chk("poll_start", n, 16);
      finish_poll();
      log_on = 0;
      if (blog.size() >= 4) begin
         chk("poll_rd_cmd", 32'(blog[0][13:8]), 32'({1'b0, 5'd0}));
         chk("poll_rd_lim", 32'(blog[1][13:8]), 32'({1'b0, 5'd2}));
         chk("poll_wr_stat", 32'(blog[2]), 32'({1'b1, 5'd1, 8'h00}));
         chk("poll_wr_cnt", 32'(blog[3]), 32'({1'b1, 5'd3, 8'h00}));
      end else begin
         chk("poll_accesses", blog.size(), 4);
      end

      // START with no limit: reset pulse, settle, run
      host_wr(5'd2, 8'd0);
      host_wr(5'd0, 8'h01);
      wait_sig("dp_rst_rise", 0, 1'b1, 100);
      hi = 0;
      do begin hi++; tick(); end while (dp_rst && hi < 50);
      chk("rst_len", hi, 5);
      n = 0;
      while (!wr_enable && n < 1000) begin tick(); n++; end
      chk("settle_len", n, 450);
      finish_poll();
      finish_poll();
      chk("cmd_cleared", 32'(ram[0]), 32'h00);
      chk("stat_run", 32'(ram[1]), 32'h03);

      // STOP, then a run with limit 10
      host_wr(5'd0, 8'h02);
      wait_sig("stop_halt", 1, 1'b0, 100);
      host_wr(5'd2, 8'd10);
      host_wr(5'd0, 8'h01);
      wait_sig("lim_run", 1, 1'b1, 1000);
      for (int i = 1; i <= 10; i++) begin
         word_tick = 1'b1;
         tick();
         if (i == 9) chk("lim_run9", 32'(wr_enable), 32'd1);
         if (i == 10) begin
            chk("lim_stop", 32'(wr_enable), 32'd0);
            chk("lim_done", 32'(done), 32'd1);
         end
         tick();
      end
      finish_poll();
      finish_poll();
      chk("stat_done", 32'(ram[1]), 32'h14);
      chk("cnt_done", 32'(ram[3]), 32'h0A);

      // overflow: fifo_full together with a word tick
      host_wr(5'd2, 8'd0);
      host_wr(5'd0, 8'h01);
      wait_sig("ovf_run", 1, 1'b1, 1000);
      for (int i = 0; i < 3; i++) begin word_tick = 1'b1; tick(); end
      word_tick = 1'b1;
      fifo_full = 1'b1;
      tick();
      chk("ovf_stop", 32'(wr_enable), 32'd0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      finish_poll();
      finish_poll();
      chk("stat_ovf", 32'(ram[1]), 32'h0C);
      chk("cnt_ovf", 32'(ram[3]), 32'h04);
      host_wr(5'd0, 8'h01);
      wait_sig("restart", 0, 1'b1, 100);
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // all command bits while running: RESET wins, ends in IDLE
      wait_sig("run_again", 1, 1'b1, 1000);
      host_wr(5'd0, 8'h07);
      wait_sig("cmd7_rst", 0, 1'b1, 100);
      wait_sig("cmd7_rst_end", 0, 1'b0, 20);
      idle(470);
      chk("cmd7_idle", 32'(wr_enable), 32'd0);
      finish_poll();
      finish_poll();
      chk("stat_idle", 32'(ram[1]), 32'h00);

      // rst in the middle of the status write
      n = 0;
      while (!(mem_en && mem_we && mem_addr == 5'd1) && n < 100) begin tick(); n++; end
      rst = 1'b1;
      tick();
      chk("rst_mid_wr", 32'({mem_en, mem_we}), 32'd0);
      n = 0;
      while (!mem_en && n < 100) begin tick(); n++; end
      chk("poll_restart", n, 16);

      // rst in the middle of settling aborts the pending run
      host_wr(5'd0, 8'h01);
      wait_sig("settle_rst_rise", 0, 1'b1, 100);
      wait_sig("settle_rst_fall", 0, 1'b0, 20);
      idle(100);
      rst = 1'b1;
      tick();
      chk("rst_mid_settle", 32'({dp_rst, wr_enable, mem_en, mem_we}), 32'd0);
      idle(500);
      chk("no_run_after_rst", 32'(wr_enable), 32'd0);

      // randomized host commands, limits, word ticks, fifo_full and rst
      for (int k = 0; k < 12000; k++) begin
         r = int'($urandom_range(999, 0));
         word_tick = 1'($urandom_range(1, 0));
         fifo_full = (r >= 998);
         if (r < 4) begin
            host_we = 1'b1; host_addr = 5'd0; host_data = cmd_tab[$urandom_range(6, 0)];
         end else if (r < 7) begin
            host_we = 1'b1; host_addr = 5'd2; host_data = 8'($urandom_range(12, 0));
         end else if (r == 500 && $urandom_range(3, 0) == 0) begin
            rst = 1'b1;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
